// File: rtl/pll_reconfig_pkg.sv
// Shared types for the PLL reconfiguration controller: FSM states, DRP register
// addresses and the CLKOUT0 divide-value encoder.
package pll_reconfig_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HOLD,
        RD1,
        WT_RD1,
        WR1,
        WT_WR1,
        RD2,
        WT_RD2,
        WR2,
        WT_WR2,
        RELEASE,
        WAIT_LOCK
    } state_t;

    localparam logic [6:0] ADDR_CLKREG1 = 7'h08;
    localparam logic [6:0] ADDR_CLKREG2 = 7'h09;

    typedef struct packed {
        logic [5:0] high;
        logic [5:0] low;
        logic       edge_bit;
        logic       nocount;
    } div_enc_t;

    function automatic div_enc_t encode_div(input logic [6:0] d);
        div_enc_t e;
        e.nocount  = (d == 7'd1);
        e.edge_bit = d[0];
        if (e.nocount) begin
            e.high = 6'd1;
            e.low  = 6'd1;
        end else begin
            e.high = d[6:1];
            e.low  = 6'(d - {1'b0, d[6:1]});
        end
        return e;
    endfunction

endpackage

// File: rtl/pll_drp_access.sv
// Single DRP read/write: strobe driven from the caller's registered start, wait
// for drdy, optional drdy timeout when PLL_RECONFIG_TIMEOUT_EN is defined.
module pll_drp_access
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned DRDY_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [6:0]  addr_i,
    input  logic [15:0] di_i,
    input  logic        drp_drdy_i,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [6:0]  drp_addr_o,
    output logic [15:0] drp_di_o,
    output logic        ack_o,
    output logic        tmo_o
);

    logic pend_q;

    assign drp_den_o  = start_i;
    assign drp_dwe_o  = start_i & we_i;
    assign drp_addr_o = addr_i;
    assign drp_di_o   = di_i;
    // drdy only counts while an access is outstanding
    assign ack_o      = pend_q & drp_drdy_i;

`ifdef PLL_RECONFIG_TIMEOUT_EN
    localparam int unsigned CW = (DRDY_TIMEOUT > 1) ? $clog2(DRDY_TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;

    assign tmo_o = pend_q & ~drp_drdy_i & (cnt_q == CW'(DRDY_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            pend_q <= 1'b1;
            cnt_q  <= '0;
        end else if (pend_q) begin
            if (ack_o || tmo_o) pend_q <= 1'b0;
            else                cnt_q  <= cnt_q + CW'(1);
        end
    end
`else
    assign tmo_o = 1'b0;

    // Timeout value has no effect in this build; kept so overrides still resolve.
    if (DRDY_TIMEOUT == 0) begin : g_drdy_timeout_inert
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)        pend_q <= 1'b0;
        else if (start_i) pend_q <= 1'b1;
        else if (ack_o)   pend_q <= 1'b0;
    end
`endif

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL CLKOUT0 divide reconfiguration over DRP with PLL reset sequencing.
// Optional timeouts on drdy and lock: define PLL_RECONFIG_TIMEOUT_EN.
module pll_reconfig_ctrl
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned DRDY_TIMEOUT = 255,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned RST_HOLD     = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic [6:0]  req_div_i,
    output logic        req_ready_o,
    output logic        done_o,
    output logic        error_o,
    output logic        busy_o,
    output logic        locked_o,
    output logic        pll_rst_o,
    input  logic        pll_locked_i,
    output logic [6:0]  drp_addr_o,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i
);

    localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    state_t        state_q;
    logic [6:0]    div_q;
    logic [HW-1:0] hold_cnt_q;
    logic [1:0]    ign_q;
    logic          meta_q, sync_q;
    logic          pll_rst_q, done_q, error_q;
    logic          start_q, we_q;
    logic [6:0]    addr_q;
    logic [15:0]   di_q;
    logic          acc_ack, acc_tmo, lock_tmo;
    div_enc_t      enc;
    logic          unused_do;

    assign enc       = encode_div(div_q);
    // ClkReg2 bits [7:6] are replaced by edge/nocount, never read back
    assign unused_do = ^drp_do_i[7:6];

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign locked_o    = sync_q & (state_q == IDLE);
    assign pll_rst_o   = pll_rst_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

    pll_drp_access #(
        .DRDY_TIMEOUT(DRDY_TIMEOUT)
    ) u_drp (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_q),
        .we_i       (we_q),
        .addr_i     (addr_q),
        .di_i       (di_q),
        .drp_drdy_i (drp_drdy_i),
        .drp_den_o  (drp_den_o),
        .drp_dwe_o  (drp_dwe_o),
        .drp_addr_o (drp_addr_o),
        .drp_di_o   (drp_di_o),
        .ack_o      (acc_ack),
        .tmo_o      (acc_tmo)
    );

`ifdef PLL_RECONFIG_TIMEOUT_EN
    localparam int unsigned LW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    logic [LW-1:0] lock_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != WAIT_LOCK) lock_cnt_q <= '0;
        else                               lock_cnt_q <= lock_cnt_q + LW'(1);
    end

    assign lock_tmo = (state_q == WAIT_LOCK) && (lock_cnt_q == LW'(LOCK_TIMEOUT - 1));
`else
    assign lock_tmo = 1'b0;

    if (LOCK_TIMEOUT == 0) begin : g_lock_timeout_inert
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            div_q      <= '0;
            hold_cnt_q <= '0;
            ign_q      <= '0;
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            pll_rst_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            start_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            di_q       <= '0;
        end else begin
            meta_q  <= pll_locked_i;
            sync_q  <= meta_q;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            start_q <= 1'b0;
            if (acc_tmo) begin
                state_q   <= IDLE;
                error_q   <= 1'b1;
                pll_rst_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (req_valid_i) begin
                        if (req_div_i == 7'd0 || req_div_i == 7'd127) begin
                            error_q <= 1'b1;
                        end else begin
                            div_q      <= req_div_i;
                            pll_rst_q  <= 1'b1;
                            hold_cnt_q <= '0;
                            state_q    <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt_q == HW'(RST_HOLD - 1)) begin
                            state_q <= RD1;
                            start_q <= 1'b1;
                            we_q    <= 1'b0;
                            addr_q  <= ADDR_CLKREG1;
                            di_q    <= '0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HW'(1);
                        end
                    end
                    RD1: state_q <= WT_RD1;
                    WT_RD1: if (acc_ack) begin
                        state_q <= WR1;
                        start_q <= 1'b1;
                        we_q    <= 1'b1;
                        di_q    <= {drp_do_i[15:12], enc.high, enc.low};
                    end
                    WR1: state_q <= WT_WR1;
                    WT_WR1: if (acc_ack) begin
                        state_q <= RD2;
                        start_q <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= ADDR_CLKREG2;
                        di_q    <= '0;
                    end
                    RD2: state_q <= WT_RD2;
                    WT_RD2: if (acc_ack) begin
                        state_q <= WR2;
                        start_q <= 1'b1;
                        we_q    <= 1'b1;
                        di_q    <= {drp_do_i[15:8], enc.edge_bit, enc.nocount, drp_do_i[5:0]};
                    end
                    WR2: state_q <= WT_WR2;
                    WT_WR2: if (acc_ack) begin
                        state_q   <= RELEASE;
                        pll_rst_q <= 1'b0;
                    end
                    RELEASE: begin
                        state_q <= WAIT_LOCK;
                        ign_q   <= '0;
                    end
                    WAIT_LOCK: begin
                        if (ign_q == 2'd2 && sync_q) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else if (lock_tmo) begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end else if (ign_q != 2'd2) begin
                            ign_q <= ign_q + 2'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Scoreboard bench for pll_reconfig_ctrl with a DRP responder and a PLL lock model.
`timescale 1ns/1ps
module tb_pll_reconfig_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic [6:0]  req_div_i;
    logic        req_ready_o, done_o, error_o, busy_o, locked_o, pll_rst_o;
    logic        pll_locked_i;
    logic [6:0]  drp_addr_o;
    logic        drp_den_o, drp_dwe_o;
    logic [15:0] drp_di_o;
    logic [15:0] drp_do_i;
    logic        drp_drdy_i;

    pll_reconfig_ctrl #(
        .DRDY_TIMEOUT(255),
        .LOCK_TIMEOUT(65535),
        .RST_HOLD(16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_div_i    (req_div_i),
        .req_ready_o  (req_ready_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .busy_o       (busy_o),
        .locked_o     (locked_o),
        .pll_rst_o    (pll_rst_o),
        .pll_locked_i (pll_locked_i),
        .drp_addr_o   (drp_addr_o),
        .drp_den_o    (drp_den_o),
        .drp_dwe_o    (drp_dwe_o),
        .drp_di_o     (drp_di_o),
        .drp_do_i     (drp_do_i),
        .drp_drdy_i   (drp_drdy_i)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    int          lat      = 2;
    bit          hold_all = 1'b0;
    bit          hold_rd9 = 1'b0;
    bit          stray    = 1'b0;
    bit          lock_en  = 1'b1;
    logic [15:0] rd8_val  = '0;
    logic [15:0] rd9_val  = '0;

    // event code: {kind[1:0], 5'b0, we, pll_rst, addr[6:0], di[15:0]}
    function automatic logic [31:0] ev_drp(input logic we, input logic rst,
                                           input logic [6:0] a, input logic [15:0] d);
        return {2'b00, 5'd0, we, rst, a, (we ? d : 16'h0000)};
    endfunction

    localparam logic [31:0] EV_DONE = {2'b10, 30'd0};
    localparam logic [31:0] EV_ERR  = {2'b11, 30'd0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic observe(input logic [31:0] ev);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %h expected none at %0t", ev, $time);
        end else begin
            check("scoreboard", ev, exp_q.pop_front());
        end
    endtask

    // Monitor: every DUT strobe/pulse becomes an event compared against the queue
    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (drp_den_o) observe(ev_drp(drp_dwe_o, pll_rst_o, drp_addr_o, drp_di_o));
                if (done_o)    observe({2'b10, 5'd0, 1'b0, pll_rst_o, 23'd0});
                if (error_o)   observe({2'b11, 5'd0, 1'b0, pll_rst_o, 23'd0});
                check("locked_while_busy", {31'd0, locked_o & busy_o}, 32'd0);
                check("ready_vs_busy", {31'd0, req_ready_o ^ busy_o}, 32'd1);
            end
        end
    end

    initial begin : drp_responder
        bit          pend;
        int          cnt;
        logic [6:0]  ca;
        logic [15:0] cd;
        logic        cw;
        pend = 1'b0; cnt = 0; ca = '0; cd = '0; cw = 1'b0;
        drp_drdy_i = 1'b0;
        drp_do_i   = '0;
        forever begin
            @(negedge clk_i);
            drp_drdy_i = 1'b0;
            if (rst_i || (pend && !busy_o)) begin
                pend = 1'b0;
            end else if (pend) begin
                check("drp_addr_stable", {25'd0, drp_addr_o}, {25'd0, ca});
                check("drp_di_stable", {16'd0, drp_di_o}, {16'd0, cd});
                cnt--;
                if (cnt <= 0 && !hold_all && !(hold_rd9 && ca == 7'h09 && !cw)) begin
                    drp_drdy_i = 1'b1;
                    drp_do_i   = cw ? 16'h0000 : ((ca == 7'h08) ? rd8_val : rd9_val);
                    pend       = 1'b0;
                end
            end else if (drp_den_o) begin
                pend = 1'b1; cnt = lat; ca = drp_addr_o; cd = drp_di_o; cw = drp_dwe_o;
            end else if (stray) begin
                drp_drdy_i = 1'b1;
                drp_do_i   = 16'hBEEF;
                stray      = 1'b0;
            end
        end
    end

    initial begin : lock_model
        int n;
        n = 0;
        pll_locked_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (pll_rst_o) begin
                pll_locked_i = 1'b0;
                n = 0;
            end else if (lock_en && !pll_locked_i) begin
                n++;
                if (n >= 5) pll_locked_i = 1'b1;
            end
        end
    end

    task automatic send(input logic [6:0] d);
        int n;
        n = 0;
        while (!req_ready_o && n < 2000) begin
            @(posedge clk_i); #1;
            n++;
        end
        req_div_i   = d;
        req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d events outstanding after %0d cycles, required 0", name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic run_legal(input logic [6:0] d, input logic [15:0] r8, input logic [15:0] r9,
                             input logic [15:0] w1, input logic [15:0] w2,
                             input bit stray_in_hold, input string name);
        rd8_val = r8;
        rd9_val = r9;
        exp_q.push_back(ev_drp(1'b0, 1'b1, 7'h08, 16'h0000));
        exp_q.push_back(ev_drp(1'b1, 1'b1, 7'h08, w1));
        exp_q.push_back(ev_drp(1'b0, 1'b1, 7'h09, 16'h0000));
        exp_q.push_back(ev_drp(1'b1, 1'b1, 7'h09, w2));
        exp_q.push_back(EV_DONE);
        send(d);
        if (stray_in_hold) stray = 1'b1;
        drain(3000, name);
        @(negedge clk_i);
        check({name, "_locked_idle"}, {31'd0, locked_o}, 32'd1);
    endtask

    task automatic run_illegal(input logic [6:0] d, input string name);
        exp_q.push_back(EV_ERR);
        send(d);
        drain(20, name);
        repeat (4) begin
            @(negedge clk_i);
            check({name, "_pll_rst"}, {31'd0, pll_rst_o}, 32'd0);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {1'b0, pll_rst_o, drp_den_o, drp_dwe_o, drp_addr_o, drp_di_o,
                done_o, error_o, busy_o, locked_o, req_ready_o};
    endfunction

    initial begin : stimulus
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_div_i   = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_outputs", out_vec(), 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;

        stray = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;

        run_legal(7'd20,  16'hF000, 16'h1234, 16'hF28A, 16'h1234, 1'b1, "div20");
        lat = 1;
        run_legal(7'd7,   16'h0000, 16'h0000, 16'h00C4, 16'h0080, 1'b0, "div7");
        lat = 4;
        run_legal(7'd1,   16'hA555, 16'h5500, 16'hA041, 16'h55C0, 1'b0, "div1");
        lat = 2;
        run_legal(7'd126, 16'h3000, 16'hFFFF, 16'h3FFF, 16'hFF3F, 1'b0, "div126");
        run_legal(7'd2,   16'h0000, 16'h00C0, 16'h0041, 16'h0000, 1'b0, "div2");

        run_illegal(7'd0,   "div0");
        run_illegal(7'd127, "div127");

`ifdef PLL_RECONFIG_TIMEOUT_EN
        hold_all = 1'b1;
        exp_q.push_back(ev_drp(1'b0, 1'b1, 7'h08, 16'h0000));
        exp_q.push_back(EV_ERR);
        send(7'd20);
        drain(400, "drdy_timeout");
        hold_all = 1'b0;
        @(negedge clk_i);
        check("drdy_timeout_state", {30'd0, pll_rst_o, req_ready_o}, 32'd1);

        lock_en = 1'b0;
        rd8_val = 16'hF000;
        rd9_val = 16'h0000;
        exp_q.push_back(ev_drp(1'b0, 1'b1, 7'h08, 16'h0000));
        exp_q.push_back(ev_drp(1'b1, 1'b1, 7'h08, 16'hF28A));
        exp_q.push_back(ev_drp(1'b0, 1'b1, 7'h09, 16'h0000));
        exp_q.push_back(ev_drp(1'b1, 1'b1, 7'h09, 16'h0000));
        exp_q.push_back(EV_ERR);
        send(7'd20);
        drain(70000, "lock_timeout");
        lock_en = 1'b1;
        @(negedge clk_i);
        check("lock_timeout_state", {30'd0, pll_rst_o, req_ready_o}, 32'd1);
`else
        lat = 300;
        run_legal(7'd20, 16'hF000, 16'h1234, 16'hF28A, 16'h1234, 1'b0, "slow_drdy");
        lat = 2;
`endif

        // Abort while ClkReg2 read is outstanding
        hold_rd9 = 1'b1;
        rd8_val  = 16'hF000;
        exp_q.push_back(ev_drp(1'b0, 1'b1, 7'h08, 16'h0000));
        exp_q.push_back(ev_drp(1'b1, 1'b1, 7'h08, 16'hF28A));
        exp_q.push_back(ev_drp(1'b0, 1'b1, 7'h09, 16'h0000));
        send(7'd20);
        drain(1000, "abort_setup");
        repeat (5) @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort_reset_outputs", out_vec(), 32'd1);
        @(posedge clk_i); #1;
        rst_i    = 1'b0;
        hold_rd9 = 1'b0;
        repeat (20) @(negedge clk_i);
        check("abort_idle", {30'd0, busy_o, pll_rst_o}, 32'd0);

        run_legal(7'd2, 16'h0000, 16'h00C0, 16'h0041, 16'h0000, 1'b0, "recover_div2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
